// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder
//   Byte-level command/response engine between the UART byte ports and the
//   vending control core. Parses 4-byte command frames (A5 CMD ARG CHK),
//   hands checksum-valid commands to the core, and returns a 4-byte response
//   frame (5A STATUS DATA CHK): the core's reply, a checksum NAK (FE), or a
//   response timeout (FD).
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   rx_data, rx_valid             received byte + one-cycle strobe
//   tx_data, tx_valid, tx_ready   byte offer to the UART transmitter
//   cmd_valid, cmd_code, cmd_arg  validated command to the core
//   rsp_valid, rsp_status, rsp_data  core reply
//   busy                          command accepted, response not yet fully sent
//   err_count                     saturating checksum-error + byte-timeout count
//
// State table
//   IDLE     | hunting for 0xA5 start byte, other bytes discarded
//   GOT_SOF  | start seen, expecting CMD
//   GOT_CMD  | CMD captured, expecting ARG
//   GOT_ARG  | ARG captured, expecting CHK
//   WAIT_RSP | command issued, waiting for core reply or response timeout
//   SEND     | emitting the 4-byte response frame
module uart_cmd_responder #(
  parameter int unsigned BYTE_TIMEOUT = 100_000,
  parameter int unsigned RSP_TIMEOUT  = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [7:0] cmd_arg,
  input  logic       rsp_valid,
  input  logic [7:0] rsp_status,
  input  logic [7:0] rsp_data,
  output logic       busy,
  output logic [7:0] err_count
);

  localparam int unsigned BW = $clog2(BYTE_TIMEOUT + 1);
  localparam int unsigned RW = $clog2(RSP_TIMEOUT + 1);

  localparam logic [7:0] SOF_CMD  = 8'hA5;
  localparam logic [7:0] SOF_RSP  = 8'h5A;
  localparam logic [7:0] ST_NAK   = 8'hFE;
  localparam logic [7:0] ST_TMO   = 8'hFD;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GOT_SOF,
    S_GOT_CMD,
    S_GOT_ARG,
    S_WAIT_RSP,
    S_SEND
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] byte_tmr_q, byte_tmr_d;
  logic [RW-1:0] rsp_tmr_q, rsp_tmr_d;
  logic [7:0]    cmd_byte_q, cmd_byte_d;
  logic [7:0]    arg_byte_q, arg_byte_d;
  logic [7:0]    cmd_code_q, cmd_code_d;
  logic [7:0]    cmd_arg_q, cmd_arg_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [7:0]    frm_status_q, frm_status_d;
  logic [7:0]    frm_data_q, frm_data_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic          tx_armed_q, tx_armed_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [7:0]    err_count_q, err_count_d;

  logic       in_parse;
  logic       byte_to;
  logic       chk_ok;
  logic       rsp_take;
  logic       rsp_to;
  logic       tx_xfer;
  logic       tx_last;
  logic       err_inc;
  logic [7:0] frm_byte;

  assign in_parse = (state_q == S_GOT_SOF) || (state_q == S_GOT_CMD) ||
                    (state_q == S_GOT_ARG);
  // A byte arriving on the cycle the timer reads zero still counts as in time.
  assign byte_to  = in_parse && !rx_valid && (byte_tmr_q == '0);
  assign chk_ok   = ((SOF_CMD ^ cmd_byte_q ^ arg_byte_q) == rx_data);
  // The core may not reply in the cmd_valid cycle itself.
  assign rsp_take = (state_q == S_WAIT_RSP) && !cmd_valid_q && rsp_valid;
  assign rsp_to   = (state_q == S_WAIT_RSP) && !rsp_take && (rsp_tmr_q == '0);
  assign tx_xfer  = (state_q == S_SEND) && tx_valid_q && tx_ready;
  assign tx_last  = tx_xfer && (byte_idx_q == 2'd3);
  assign err_inc  = ((state_q == S_GOT_ARG) && rx_valid && !chk_ok) || byte_to;

  always_comb begin
    case (byte_idx_q)
      2'd0:    frm_byte = SOF_RSP;
      2'd1:    frm_byte = frm_status_q;
      2'd2:    frm_byte = frm_data_q;
      default: frm_byte = SOF_RSP ^ frm_status_q ^ frm_data_q;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      byte_tmr_q   <= '0;
      rsp_tmr_q    <= '0;
      cmd_byte_q   <= 8'h00;
      arg_byte_q   <= 8'h00;
      cmd_code_q   <= 8'h00;
      cmd_arg_q    <= 8'h00;
      cmd_valid_q  <= 1'b0;
      frm_status_q <= 8'h00;
      frm_data_q   <= 8'h00;
      byte_idx_q   <= 2'd0;
      tx_armed_q   <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      err_count_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      byte_tmr_q   <= byte_tmr_d;
      rsp_tmr_q    <= rsp_tmr_d;
      cmd_byte_q   <= cmd_byte_d;
      arg_byte_q   <= arg_byte_d;
      cmd_code_q   <= cmd_code_d;
      cmd_arg_q    <= cmd_arg_d;
      cmd_valid_q  <= cmd_valid_d;
      frm_status_q <= frm_status_d;
      frm_data_q   <= frm_data_d;
      byte_idx_q   <= byte_idx_d;
      tx_armed_q   <= tx_armed_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      err_count_q  <= err_count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (rx_valid && (rx_data == SOF_CMD)) state_d = S_GOT_SOF;
      S_GOT_SOF:  if (rx_valid) state_d = S_GOT_CMD;
                  else if (byte_to) state_d = S_IDLE;
      S_GOT_CMD:  if (rx_valid) state_d = S_GOT_ARG;
                  else if (byte_to) state_d = S_IDLE;
      S_GOT_ARG:  if (rx_valid) state_d = chk_ok ? S_WAIT_RSP : S_SEND;
                  else if (byte_to) state_d = S_IDLE;
      S_WAIT_RSP: if (rsp_take || rsp_to) state_d = S_SEND;
      S_SEND:     if (tx_last) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Datapath / output logic
  always_comb begin
    byte_tmr_d   = byte_tmr_q;
    rsp_tmr_d    = rsp_tmr_q;
    cmd_byte_d   = cmd_byte_q;
    arg_byte_d   = arg_byte_q;
    cmd_code_d   = cmd_code_q;
    cmd_arg_d    = cmd_arg_q;
    cmd_valid_d  = 1'b0;
    frm_status_d = frm_status_q;
    frm_data_d   = frm_data_q;
    byte_idx_d   = byte_idx_q;
    tx_armed_d   = tx_armed_q;
    tx_valid_d   = 1'b0;
    tx_data_d    = tx_data_q;
    err_count_d  = err_count_q;

    if (err_inc && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;

    if (((state_q == S_IDLE) && rx_valid && (rx_data == SOF_CMD)) ||
        (in_parse && rx_valid)) begin
      byte_tmr_d = BW'(BYTE_TIMEOUT - 1);
    end else if (in_parse && (byte_tmr_q != '0)) begin
      byte_tmr_d = byte_tmr_q - 1'b1;
    end

    case (state_q)
      S_GOT_SOF: if (rx_valid) cmd_byte_d = rx_data;
      S_GOT_CMD: if (rx_valid) arg_byte_d = rx_data;
      S_GOT_ARG: begin
        if (rx_valid) begin
          if (chk_ok) begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = cmd_byte_q;
            cmd_arg_d   = arg_byte_q;
            rsp_tmr_d   = RW'(RSP_TIMEOUT);
          end else begin
            frm_status_d = ST_NAK;
            frm_data_d   = cmd_byte_q;
            byte_idx_d   = 2'd0;
            tx_armed_d   = 1'b1;
          end
        end
      end
      S_WAIT_RSP: begin
        if (rsp_take) begin
          frm_status_d = rsp_status;
          frm_data_d   = rsp_data;
          byte_idx_d   = 2'd0;
          tx_armed_d   = 1'b1;
        end else if (rsp_to) begin
          frm_status_d = ST_TMO;
          frm_data_d   = cmd_byte_q;
          byte_idx_d   = 2'd0;
          tx_armed_d   = 1'b1;
        end else begin
          rsp_tmr_d = rsp_tmr_q - 1'b1;
        end
      end
      S_SEND: begin
        // One-cycle offer; after a transfer, wait for tx_ready to go low
        // and high again before offering the next byte.
        if (tx_valid_q) begin
          if (tx_ready) begin
            byte_idx_d = byte_idx_q + 2'd1;
            tx_armed_d = 1'b0;
          end
        end else if (!tx_armed_q) begin
          if (!tx_ready) tx_armed_d = 1'b1;
        end else if (tx_ready) begin
          tx_valid_d = 1'b1;
          tx_data_d  = frm_byte;
        end
      end
      default: ;
    endcase
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign cmd_arg   = cmd_arg_q;
  assign busy      = (state_q == S_WAIT_RSP) || (state_q == S_SEND);
  assign err_count = err_count_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
module tb_uart_cmd_responder;

  localparam int BT = 16;
  localparam int RT = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic [7:0] cmd_arg;
  logic       rsp_valid = 1'b0;
  logic [7:0] rsp_status = 8'h00;
  logic [7:0] rsp_data = 8'h00;
  logic       busy;
  logic [7:0] err_count;

  int errors = 0;
  int checks = 0;

  logic [7:0] tx_log[$];
  int  cv_cnt = 0;
  int  viol = 0;
  logic prev_tv = 1'b0;
  int  hold = 0;
  bit  pend = 1'b0;

  uart_cmd_responder #(.BYTE_TIMEOUT(BT), .RSP_TIMEOUT(RT)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_arg(cmd_arg),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_data(rsp_data),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Transmitter model: accepts a byte, drops ready for a few cycles, then idles again.
  always @(negedge clk) begin
    if (rst) begin
      tx_ready = 1'b1;
      hold = 0;
      pend = 1'b0;
      prev_tv = 1'b0;
    end else begin
      if (tx_valid && prev_tv) viol++;
      prev_tv = tx_valid;
      if (pend) begin
        tx_ready = 1'b0;
        hold = 2;
        pend = 1'b0;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) tx_ready = 1'b1;
      end
      if (tx_valid && tx_ready) begin
        tx_log.push_back(tx_data);
        pend = 1'b1;
      end
      if (cmd_valid) cv_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    rsp_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic send_frame(input logic [31:0] f);
    send_byte(f[31:24]);
    send_byte(f[23:16]);
    send_byte(f[15:8]);
    send_byte(f[7:0]);
  endtask

  task automatic reply(input logic [7:0] st, input logic [7:0] dt);
    rsp_status = st;
    rsp_data = dt;
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
  endtask

  // Waits (bounded) for four logged bytes from index base; X on timeout.
  task automatic get_frame(input int base, output logic [31:0] f);
    for (int i = 0; i < 600 && tx_log.size() < base + 4; i++) tick();
    if (tx_log.size() >= base + 4)
      f = {tx_log[base], tx_log[base+1], tx_log[base+2], tx_log[base+3]};
    else
      f = 32'hxxxxxxxx;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b expected 0", cmd_valid); end
    checks++; if ({cmd_code, cmd_arg} !== 16'h0000) begin errors++; $display("FAIL reset_cmd: got %h%h expected 0000", cmd_code, cmd_arg); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL reset_err: got %h expected 00", err_count); end
  endtask

  task automatic test_valid_cmd();
    int base, c0;
    logic [31:0] f;
    do_reset();
    base = tx_log.size();
    c0 = cv_cnt;
    send_frame(32'hA5102297);
    checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL valid_cmd_valid: got %b expected 1", cmd_valid); end
    checks++; if (cmd_code !== 8'h10) begin errors++; $display("FAIL valid_cmd_code: got %h expected 10", cmd_code); end
    checks++; if (cmd_arg !== 8'h22) begin errors++; $display("FAIL valid_cmd_arg: got %h expected 22", cmd_arg); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL valid_busy_rise: got %b expected 1", busy); end
    tick();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL valid_cmd_pulse: got %b expected 0", cmd_valid); end
    reply(8'h00, 8'h33);
    get_frame(base, f);
    checks++; if (f !== 32'h5A003369) begin errors++; $display("FAIL valid_frame: got %h expected 5a003369", f); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL valid_busy_fall: got %b expected 0", busy); end
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL valid_err: got %h expected 00", err_count); end
    checks++; if (cv_cnt - c0 !== 1) begin errors++; $display("FAIL valid_cv_count: got %0d expected 1", cv_cnt - c0); end
  endtask

  // Runs straight after test_valid_cmd: the next frame starts as busy falls.
  task automatic test_back_to_back();
    int base;
    logic [31:0] f;
    base = tx_log.size();
    send_frame(32'hA50102A6);
    checks++; if ({cmd_valid, cmd_code, cmd_arg} !== 17'h10102) begin errors++; $display("FAIL b2b_cmd: got %b %h %h expected 1 01 02", cmd_valid, cmd_code, cmd_arg); end
    tick();
    reply(8'h7F, 8'h80);
    get_frame(base, f);
    checks++; if (f !== 32'h5A7F80A5) begin errors++; $display("FAIL b2b_frame: got %h expected 5a7f80a5", f); end
  endtask

  task automatic test_bad_chk();
    int base, c0;
    logic [31:0] f;
    do_reset();
    base = tx_log.size();
    c0 = cv_cnt;
    send_frame(32'hA5102200);
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL badchk_cmd_valid: got %b expected 0", cmd_valid); end
    checks++; if (err_count !== 8'h01) begin errors++; $display("FAIL badchk_err: got %h expected 01", err_count); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL badchk_busy: got %b expected 1", busy); end
    get_frame(base, f);
    checks++; if (f !== 32'h5AFE10B4) begin errors++; $display("FAIL badchk_frame: got %h expected 5afe10b4", f); end
    checks++; if (cv_cnt !== c0) begin errors++; $display("FAIL badchk_cv_count: got %0d expected %0d", cv_cnt, c0); end
  endtask

  task automatic test_byte_timeout();
    int base;
    do_reset();
    base = tx_log.size();
    send_byte(8'hA5);
    send_byte(8'h10);
    repeat (BT - 1) tick();
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL byteto_early: got %h expected 00", err_count); end
    tick();
    checks++; if (err_count !== 8'h01) begin errors++; $display("FAIL byteto_err: got %h expected 01", err_count); end
    repeat (10) tick();
    checks++; if (tx_log.size() !== base) begin errors++; $display("FAIL byteto_no_tx: got %0d bytes expected 0", tx_log.size() - base); end
    send_frame(32'hA5102297);
    checks++; if ({cmd_valid, cmd_code} !== 9'h110) begin errors++; $display("FAIL byteto_recover: got %b %h expected 1 10", cmd_valid, cmd_code); end
    // Gap of BYTE_TIMEOUT-1 idle cycles is still inside the window.
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h10);
    repeat (BT - 1) tick();
    send_byte(8'h22);
    send_byte(8'h97);
    checks++; if ({cmd_valid, err_count} !== 9'h100) begin errors++; $display("FAIL byteto_edge: got %b %h expected 1 00", cmd_valid, err_count); end
  endtask

  task automatic test_rsp_timeout();
    int base;
    logic [31:0] f;
    do_reset();
    base = tx_log.size();
    send_frame(32'hA5102297);
    repeat (RT + 1) tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rspto_early: got %b expected 0", tx_valid); end
    tick();
    checks++; if ({tx_valid, tx_data} !== 9'h15A) begin errors++; $display("FAIL rspto_first: got %b %h expected 1 5a", tx_valid, tx_data); end
    get_frame(base, f);
    checks++; if (f !== 32'h5AFD10B7) begin errors++; $display("FAIL rspto_frame: got %h expected 5afd10b7", f); end
    // Reply landing in the expiry cycle takes priority.
    do_reset();
    base = tx_log.size();
    send_frame(32'hA5102297);
    repeat (RT) tick();
    reply(8'h00, 8'h44);
    get_frame(base, f);
    checks++; if (f !== 32'h5A00441E) begin errors++; $display("FAIL rspto_edge_win: got %h expected 5a00441e", f); end
  endtask

  task automatic test_busy_drop();
    int base, c0;
    logic [31:0] f;
    do_reset();
    base = tx_log.size();
    c0 = cv_cnt;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(32'hA5102297);
    checks++; if ({cmd_valid, cmd_code} !== 9'h110) begin errors++; $display("FAIL junk_cmd: got %b %h expected 1 10", cmd_valid, cmd_code); end
    tick();
    send_frame(32'hA52030B5);
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL drop_cmd_valid: got %b expected 0", cmd_valid); end
    checks++; if (cmd_code !== 8'h10) begin errors++; $display("FAIL drop_cmd_code: got %h expected 10", cmd_code); end
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL drop_err: got %h expected 00", err_count); end
    reply(8'h01, 8'h02);
    get_frame(base, f);
    checks++; if (f !== 32'h5A010259) begin errors++; $display("FAIL drop_frame: got %h expected 5a010259", f); end
    checks++; if (cv_cnt - c0 !== 1) begin errors++; $display("FAIL drop_cv_count: got %0d expected 1", cv_cnt - c0); end
    tick();
    reply(8'h00, 8'h00);
    repeat (10) tick();
    checks++; if ({busy, tx_log.size() == base + 4} !== 2'b01) begin errors++; $display("FAIL stray_rsp: got busy=%b bytes=%0d expected busy=0 bytes=4", busy, tx_log.size() - base); end
  endtask

  task automatic test_err_saturate();
    logic [31:0] f;
    int base;
    do_reset();
    for (int i = 0; i < 255; i++) begin
      base = tx_log.size();
      send_frame(32'hA5102200);
      get_frame(base, f);
    end
    checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL sat_255: got %h expected ff", err_count); end
    base = tx_log.size();
    send_frame(32'hA5102200);
    get_frame(base, f);
    checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL sat_hold: got %h expected ff", err_count); end
    checks++; if (f !== 32'h5AFE10B4) begin errors++; $display("FAIL sat_frame: got %h expected 5afe10b4", f); end
  endtask

  task automatic test_reset_mid_send();
    int base;
    logic [31:0] f;
    do_reset();
    base = tx_log.size();
    send_frame(32'hA5102297);
    tick();
    reply(8'h00, 8'h33);
    for (int i = 0; i < 200 && tx_log.size() < base + 2; i++) tick();
    rst = 1'b1;
    tick();
    checks++; if ({tx_valid, busy, cmd_valid} !== 3'b000) begin errors++; $display("FAIL rstmid_ctrl: got %b%b%b expected 000", tx_valid, busy, cmd_valid); end
    checks++; if ({tx_data, cmd_code, cmd_arg, err_count} !== 32'h0) begin errors++; $display("FAIL rstmid_data: got %h %h %h %h expected zeros", tx_data, cmd_code, cmd_arg, err_count); end
    rst = 1'b0;
    repeat (30) tick();
    checks++; if (tx_log.size() !== base + 2) begin errors++; $display("FAIL rstmid_no_more: got %0d bytes expected 2", tx_log.size() - base); end
    send_frame(32'hA5102297);
    checks++; if ({cmd_valid, cmd_code, cmd_arg} !== 17'h11022) begin errors++; $display("FAIL rstmid_cmd: got %b %h %h expected 1 10 22", cmd_valid, cmd_code, cmd_arg); end
    tick();
    reply(8'h00, 8'h33);
    get_frame(base + 2, f);
    checks++; if (f !== 32'h5A003369) begin errors++; $display("FAIL rstmid_frame: got %h expected 5a003369", f); end
  endtask

  task automatic test_handshake();
    checks++; if (viol !== 0) begin errors++; $display("FAIL tx_valid_width: got %0d multi-cycle offers expected 0", viol); end
  endtask

  initial begin
    test_reset();
    test_valid_cmd();
    test_back_to_back();
    test_bad_chk();
    test_byte_timeout();
    test_rsp_timeout();
    test_busy_drop();
    test_err_saturate();
    test_reset_mid_send();
    test_handshake();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
